pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
- Parametrised program-counter and next-address unit for the processor datapath.
- Holds the PC and computes the next PC: sequential step, relative branch, absolute jump, or return.
- Contains a configurable-depth hardware return-address stack with full/empty status, a selectable overflow policy, and sticky error flags.
- Feeds the instruction memory address and is driven by the controller's PC-select, call and enable lines.

Parameters:
ADDR_WIDTH, 12, PC and return-address width in bits
DISP_WIDTH, 8, branch displacement width in bits (two's complement); must be <= ADDR_WIDTH
STACK_DEPTH, 8, return-stack entries (>= 2, power of two not required)
OVF_WRAP, 0, 0 = push when full is dropped and flagged; 1 = push when full overwrites oldest entry and is flagged
RESET_VECTOR, 0, PC value after reset

Ports:
clk  in  1  clock, rising-edge
rst  in  1  reset, asynchronous, active-low
en  in  1  PC update enable; 0 = stall (nothing changes)
sel  in  2  next-PC source: 00 pc+1, 01 pc+1+sext(disp), 10 target, 11 return (pop)
call  in  1  push pc+1 onto return stack this cycle
disp  in  DISP_WIDTH  signed branch displacement
target  in  ADDR_WIDTH  absolute jump/call address
err_clear  in  1  clears sticky error flags
pc  out  ADDR_WIDTH  current PC (registered)
pc_plus1  out  ADDR_WIDTH  pc+1, combinational
stack_top  out  ADDR_WIDTH  top-of-stack value, combinational; 0 when empty
stack_count  out  clog2(STACK_DEPTH+1)  valid entries
stack_full  out  1  stack_count == STACK_DEPTH
stack_empty  out  1  stack_count == 0
overflow  out  1  sticky: push attempted while full
underflow  out  1  sticky: return attempted while empty

Behaviour:
- Reset (rst=0, asynchronous, any time including mid-stall): pc=RESET_VECTOR, stack_count=0, top pointer=0, overflow=0, underflow=0. Stack storage is not cleared; its contents are don't-care. Release is synchronous to clk.
- All state updates occur on the rising clk edge only when en=1. With en=0, sel, call and disp are ignored and pc, stack and flags hold. err_clear acts regardless of en.
- Arithmetic: all PC arithmetic is modulo 2^ADDR_WIDTH. pc+1 at all-ones wraps to 0. disp is sign-extended to ADDR_WIDTH and added to pc+1.
- sel=00: pc <= pc+1.
- sel=01: pc <= pc+1+sext(disp).
- sel=10: pc <= target.
- sel=11, stack not empty: pc <= stack_top; pop (count-1).
- sel=11, stack empty: pc <= pc+1; underflow <= 1; count stays 0.
- call=1: push pc+1 (value before the edge). call is independent of sel; the controller normally pairs call with sel=10.
- call=1 with sel=11 on a non-empty stack: pop and push in the same edge. pc <= old top; the top entry is replaced by pc+1; count unchanged; no flag.
- call=1 with sel=11 on an empty stack: underflow <= 1; push proceeds (count becomes 1); pc <= pc+1.
- Push while full, OVF_WRAP=0: entry is discarded; stack unchanged; overflow <= 1.
- Push while full, OVF_WRAP=1: the circular top pointer advances and overwrites the oldest entry; count stays STACK_DEPTH; overflow <= 1.
- Storage: circular buffer indexed by the top pointer, modulo STACK_DEPTH, so a non-power-of-two depth wraps correctly.
- Sticky flags: once set, overflow and underflow hold until err_clear=1 or reset. If err_clear and a new error occur in the same cycle, the flag ends set (set wins).
- Latency: pc, count and flags update one edge after the request. stack_top, pc_plus1, stack_full and stack_empty follow combinationally from registered state.

Test Plan:
- Reset and sequential step: reset held, RESET_VECTOR=0; release with en=1, sel=00 for 3 edges -> pc=3. Assert rst mid-run -> pc=0 immediately, before any clk edge.
- Branch with wrap: pc=0xFFE, sel=01, disp=0x02 -> pc=0x001. Then pc=0x005, disp=0xFA (-6) -> pc=0x000.
- Call/return with stall: pc=0x010, call=1, sel=10, target=0x200 -> pc=0x200, stack_top=0x011, count=1. Hold en=0 for 2 edges -> no change. Then sel=11 -> pc=0x011, stack_empty=1.
- Overflow, OVF_WRAP=0, depth 8: 9 consecutive calls -> count=8, overflow=1. 8 returns give the first 8 return addresses in LIFO order; a 9th return -> underflow=1, pc=pc+1.
- Overflow, OVF_WRAP=1, depth 8: 9 calls -> count=8. Returns yield calls 9 down to 2; the first call's address is lost.
- Simultaneous call+return: stack [0x100], pc=0x050, call=1, sel=11 -> pc=0x100, top=0x051, count=1. Then err_clear with a concurrent new underflow -> underflow remains 1.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program counter and next-address unit.
// Includes a circular hardware return-address stack with sticky overflow and underflow flags.
module pc_sequencer #(
  parameter int                    ADDR_WIDTH   = 12,
  parameter int                    DISP_WIDTH   = 8,
  parameter int                    STACK_DEPTH  = 8,
  parameter bit                    OVF_WRAP     = 1'b0,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               en,
  input  logic [1:0]                         sel,
  input  logic                               call,
  input  logic [DISP_WIDTH-1:0]              disp,
  input  logic [ADDR_WIDTH-1:0]              target,
  input  logic                               err_clear,
  output logic [ADDR_WIDTH-1:0]              pc,
  output logic [ADDR_WIDTH-1:0]              pc_plus1,
  output logic [ADDR_WIDTH-1:0]              stack_top,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_count,
  output logic                               stack_full,
  output logic                               stack_empty,
  output logic                               overflow,
  output logic                               underflow
);

  localparam int PW = $clog2(STACK_DEPTH);
  localparam int CW = $clog2(STACK_DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(STACK_DEPTH);
  localparam logic [PW-1:0] LAST_C  = PW'(STACK_DEPTH-1);

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [CW-1:0]         count_q, count_d;
  logic [PW-1:0]         top_q, top_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic [ADDR_WIDTH-1:0] stack_mem [STACK_DEPTH];
  logic                  wr_en;
  logic [PW-1:0]         wr_addr;

  logic [ADDR_WIDTH-1:0] disp_ext;
  logic [PW-1:0]         top_inc, top_dec;
  logic                  pop, push, ovf_set, unf_set;

  always_comb begin
    pc_plus1    = pc_q + ADDR_WIDTH'(1);
    stack_empty = (count_q == '0);
    stack_full  = (count_q == DEPTH_C);
    stack_top   = stack_empty ? '0 : stack_mem[top_q];
    top_inc     = (top_q == LAST_C) ? '0 : top_q + PW'(1);
    top_dec     = (top_q == '0) ? LAST_C : top_q - PW'(1);
    disp_ext    = {ADDR_WIDTH{disp[DISP_WIDTH-1]}};
    disp_ext[DISP_WIDTH-1:0] = disp;
  end

  // A pop paired with a push rewrites the current top in place.
  always_comb begin
    pc_d    = pc_q;
    count_d = count_q;
    top_d   = top_q;
    wr_en   = 1'b0;
    wr_addr = top_q;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    pop     = en && (sel == 2'b11) && !stack_empty;
    push    = en && call;

    if (en) begin
      case (sel)
        2'b00: pc_d = pc_plus1;
        2'b01: pc_d = pc_plus1 + disp_ext;
        2'b10: pc_d = target;
        default: begin
          pc_d    = stack_empty ? pc_plus1 : stack_top;
          unf_set = stack_empty;
        end
      endcase
    end

    if (pop && push) begin
      wr_en = 1'b1;
    end else if (pop) begin
      top_d   = top_dec;
      count_d = count_q - CW'(1);
    end else if (push) begin
      if (!stack_full) begin
        top_d   = top_inc;
        count_d = count_q + CW'(1);
        wr_en   = 1'b1;
        wr_addr = top_inc;
      end else begin
        ovf_set = 1'b1;
        if (OVF_WRAP) begin
          top_d   = top_inc;
          wr_en   = 1'b1;
          wr_addr = top_inc;
        end
      end
    end

    overflow_d  = (overflow_q  & ~err_clear) | ovf_set;
    underflow_d = (underflow_q & ~err_clear) | unf_set;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q        <= RESET_VECTOR;
      count_q     <= '0;
      top_q       <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      count_q     <= count_d;
      top_q       <= top_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Stack contents are don't-care after reset, so the storage has no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      stack_mem[wr_addr] <= pc_plus1;
    end
  end

  assign pc          = pc_q;
  assign stack_count = count_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;

endmodule
